// File: rtl/alu_bit_serial_ctrl.sv
// rtl/alu_bit_serial_ctrl.sv - bit-serial ALU initiator driving one external 1-bit slice
// Optional feature macro: ZERO_FLAG_EN (adds the zero output and its register).
module alu_bit_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
`ifdef ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [2:0]       slice_sel,
    output logic             slice_a,
    output logic             slice_b,
    input  logic             slice_dout,
    input  logic             slice_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LESS = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [WIDTH-1:0]  res_q;
    logic [CW-1:0]     cnt_q;
    logic              c_q;
    logic              carry_q;

    logic              accept;
    logic              running;
    logic              last_bit;
    logic [2:0]        sel_map;
    logic              is_less;
    logic              is_arith;
    logic              r_bit;
    logic              c_next;

    assign running  = (state_q == S_RUN);
    assign accept   = start && !running;
    assign last_bit = running && (cnt_q == LAST_BIT);
    assign is_less  = (op_q == OP_LESS);
    assign is_arith = (sel_map == OP_ADD) || (sel_map == OP_SUB);

    // LESS is an unsigned compare done as a subtract; unused opcodes fall back to ADD.
    always_comb begin
        sel_map = OP_ADD;
        case (op_q)
            OP_AND:  sel_map = OP_AND;
            OP_OR:   sel_map = OP_OR;
            OP_SUB:  sel_map = OP_SUB;
            OP_LESS: sel_map = OP_SUB;
            default: sel_map = OP_ADD;
        endcase
    end

    // The slice only gives a half add/sub, so the running carry/borrow is folded in here.
    always_comb begin
        r_bit  = slice_dout;
        c_next = 1'b0;
        if (sel_map == OP_ADD) begin
            r_bit  = slice_dout ^ c_q;
            c_next = slice_cout | (slice_dout & c_q);
        end else if (sel_map == OP_SUB) begin
            r_bit  = slice_dout ^ c_q;
            c_next = slice_cout | (~slice_dout & c_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_RUN : S_IDLE;
            S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = running;
        done      = (state_q == S_DONE);
        slice_sel = running ? sel_map : 3'b000;
        slice_a   = running & a_sh_q[0];
        slice_b   = running & b_sh_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 3'b000;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
        end else if (running) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
            cnt_q  <= cnt_q + 1'b1;
            c_q    <= c_next;
            if (last_bit && is_less) begin
                res_q <= {{(WIDTH-1){1'b0}}, c_next};
            end else begin
                res_q <= {r_bit, res_q[WIDTH-1:1]};
            end
            if (last_bit) begin
                carry_q <= is_arith & ~is_less & c_next;
            end
        end
    end

    assign result = res_q;
    assign carry  = carry_q;

`ifdef ZERO_FLAG_EN
    logic zero_q;

    // For LESS the committed difference bits are discarded, so zero follows the compare outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= 1'b1;
        end else if (running) begin
            if (last_bit && is_less) begin
                zero_q <= ~c_next;
            end else if (r_bit) begin
                zero_q <= 1'b0;
            end
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_bit_serial_ctrl.sv
// tb/tb_alu_bit_serial_ctrl.sv - randomized self-checking bench for alu_bit_serial_ctrl
// Covers ZERO_FLAG_EN when the same macro is defined for the bench.
module tb_alu_bit_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
`ifdef ZERO_FLAG_EN
    logic         zero;
`endif
    logic [2:0]   slice_sel;
    logic         slice_a;
    logic         slice_b;
    logic         slice_dout;
    logic         slice_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_bit_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry      (carry),
`ifdef ZERO_FLAG_EN
        .zero       (zero),
`endif
        .slice_sel  (slice_sel),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_dout (slice_dout),
        .slice_cout (slice_cout)
    );

    // External 1-bit slice: AND, OR, half-add, half-sub.
    always_comb begin
        slice_dout = 1'b0;
        slice_cout = 1'b0;
        case (slice_sel)
            3'b000: slice_dout = slice_a & slice_b;
            3'b001: slice_dout = slice_a | slice_b;
            3'b010: begin slice_dout = slice_a ^ slice_b; slice_cout = slice_a & slice_b;  end
            3'b011: begin slice_dout = slice_a ^ slice_b; slice_cout = ~slice_a & slice_b; end
            default: begin slice_dout = 1'b0; slice_cout = 1'b0; end
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic c);
        int unsigned ia, ib, t;
        ia = a;
        ib = b;
        c  = 1'b0;
        case (o)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd3: begin t = ia - ib; r = W'(t); c = (ia < ib); end
            3'd4: r = (ia < ib) ? W'(1) : W'(0);
            default: begin t = ia + ib; r = W'(t); c = (t >= (1 << W)); end
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input logic [2:0] o);
        if (o == 3'd0) return 3'd0;
        if (o == 3'd1) return 3'd1;
        if (o == 3'd3 || o == 3'd4) return 3'd3;
        return 3'd2;
    endfunction

    // Model: remaining bit count, held results, pending answer computed arithmetically.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [2:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_car = 1'b0, p_car = 1'b0;
    logic         m_zero = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_res = '0; m_car = 1'b0; m_zero = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1; m_res = p_res; m_car = p_car; m_zero = (p_res == '0);
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_op = op; m_a = a_in; m_b = b_in;
                ref_op(op, a_in, b_in, p_res, p_car);
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            if (m_left == 0) begin
                chk("result", result, m_res);
                chk("carry", carry, m_car);
`ifdef ZERO_FLAG_EN
                chk("zero", zero, m_zero);
`endif
                chk("idle_sel", slice_sel, 3'd0);
                chk("idle_ab", {slice_a, slice_b}, 2'b00);
            end else begin
                chk("run_sel", slice_sel, sel_of(m_op));
                chk("run_a", slice_a, m_a[W - m_left]);
                chk("run_b", slice_b, m_b[W - m_left]);
            end
        end
    end

    logic [2:0] mid_sel;

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; a_in = a; b_in = b; start = 1'b1;
    endtask

    // Called right after issue(); returns at the negedge where done is seen.
    task automatic wait_done(input int poke, output int n, output int bc);
        @(negedge clk);
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
        n = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (n == 2) mid_sel = slice_sel;
            start = (n == poke);
            if (start) begin op = 3'($urandom); a_in = W'($urandom); b_in = W'($urandom); end
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic dir(input string nm, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ec, input int poke);
        int n, bc;
        @(negedge clk);
        issue(o, a, b);
        wait_done(poke, n, bc);
        chk({nm, "_lat"}, n, W);
        chk({nm, "_busy_cycles"}, bc, W);
        chk({nm, "_res"}, result, er);
        chk({nm, "_carry"}, carry, ec);
        chk({nm, "_model"}, m_res, er);
    endtask

    initial begin
        int n, bc;
        bit b2b;
        logic [2:0] o;
        logic [W-1:0] a, b;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_slice", {slice_sel, slice_a, slice_b}, 0);
        rst_n = 1'b1;

        dir("add_c8_64", 3'd2, 8'hC8, 8'h64, 8'h2C, 1'b1, -1);
        dir("sub_05_07", 3'd3, 8'h05, 8'h07, 8'hFE, 1'b1, -1);
        dir("sub_07_05", 3'd3, 8'h07, 8'h05, 8'h02, 1'b0, -1);
        dir("less_03_fa", 3'd4, 8'h03, 8'hFA, 8'h01, 1'b0, -1);
        chk("less_sel", mid_sel, 3'b011);
        dir("less_fa_03", 3'd4, 8'hFA, 8'h03, 8'h00, 1'b0, -1);
        dir("less_77_77", 3'd4, 8'h77, 8'h77, 8'h00, 1'b0, -1);
        dir("and", 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, -1);
        dir("or", 3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0, -1);
        dir("op111", 3'd7, 8'h01, 8'h01, 8'h02, 1'b0, -1);
        dir("ignore_start", 3'd2, 8'h10, 8'h22, 8'h32, 1'b0, 3);
`ifdef ZERO_FLAG_EN
        dir("sub_5a_5a", 3'd3, 8'h5A, 8'h5A, 8'h00, 1'b0, -1);
        chk("zero_set", zero, 1);
        dir("add_00_01", 3'd2, 8'h00, 8'h01, 8'h01, 1'b0, -1);
        chk("zero_clr", zero, 0);
`endif

        // Back-to-back: start again in the DONE cycle.
        issue(3'd2, 8'hFF, 8'h01);
        wait_done(-1, n, bc);
        chk("b2b_res", result, 8'h00);
        chk("b2b_carry", carry, 1);

        // Reset mid-run.
        @(negedge clk);
        issue(3'd2, 8'hFF, 8'hFF);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_slice", {slice_sel, slice_a, slice_b}, 0);
        @(negedge clk); rst_n = 1'b1;
        dir("post_rst_add", 3'd2, 8'h01, 8'h01, 8'h02, 1'b0, -1);

        b2b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = W'($urandom);
            b = W'($urandom);
            if (!b2b) @(negedge clk);
            issue(o, a, b);
            wait_done(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1, n, bc);
            chk("rand_lat", n, W);
            b2b = 1'($urandom_range(0, 1));
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
